pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the single-cycle/pipelined CPU datapath. Holds the fetch address, advances it by one instruction per cycle, and accepts PC-relative branch and absolute jump redirects. It also supports a stall hold, inserts a configurable number of fetch bubbles after each redirect, and flags misaligned jump targets. It sits between the control unit/ALU (redirect sources) and instruction memory (PC consumer).

## Interface
Parameters:
- WIDTH, 32, PC width in bits
- RESET_VECTOR, 0, PC value loaded on reset
- INSTR_BYTES, 4, bytes per instruction (power of two, ≥1)
- OFFSET_W, 8, width of signed branch offset (in instructions)
- BUBBLES, 1, invalid fetch cycles inserted after a redirect (0–7)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- STALL  in  1  hold PC and state this cycle
- BRANCH_EN  in  1  take PC-relative branch
- JUMP_EN  in  1  take absolute jump
- OFFSET  in  OFFSET_W  signed branch offset, in instructions
- TARGET  in  WIDTH  absolute jump address
- PC  out  WIDTH  current fetch address
- PC_PLUS  out  WIDTH  PC + INSTR_BYTES (link value)
- INSTR_VALID  out  1  PC is a valid fetch this cycle
- REDIRECT  out  1  a redirect was accepted at the last edge
- MISALIGN  out  1  the last accepted jump target had nonzero low bits

## Operation
- States: BOOT, RUN, BUBBLE.
- Reset (RESET=0, any time, asynchronous):
  - PC=RESET_VECTOR; state=BOOT; bubble counter=0.
  - INSTR_VALID=0, REDIRECT=0, MISALIGN=0.
  - PC_PLUS=RESET_VECTOR+INSTR_BYTES.
- BOOT: one cycle. PC held, INSTR_VALID=0. Goes to RUN at the next edge, unless STALL is high (then it stays in BOOT).
- Priority at each edge: STALL > JUMP_EN > BRANCH_EN > sequential.
- STALL=1: PC, state and counter hold. Redirect requests are ignored; the requester keeps them asserted until STALL drops. REDIRECT and MISALIGN go to 0.
- JUMP_EN=1: PC ← TARGET with low log2(INSTR_BYTES) bits forced to 0. MISALIGN=1 if those bits were nonzero.
- BRANCH_EN=1 (JUMP_EN=0): PC ← PC_PLUS + (sign-extended OFFSET << log2(INSTR_BYTES)).
- Redirect accepted: REDIRECT=1 for one cycle. If BUBBLES>0: state=BUBBLE, counter=BUBBLES, and INSTR_VALID=0. If BUBBLES=0: stay in RUN with INSTR_VALID=1.
- BUBBLE:
  - PC holds at the redirect target.
  - Counter decrements each unstalled edge; at 1→0 the state goes to RUN.
  - A redirect during BUBBLE is accepted and reloads the counter.
- RUN, no request: PC ← PC_PLUS, INSTR_VALID=1.
- Arithmetic is modulo 2^WIDTH. Wrap from 2^WIDTH−INSTR_BYTES to 0 is silent. A negative branch below 0 wraps.

## Timing
- All outputs are registered, except PC_PLUS, which is combinational from PC.
- Requests are sampled at a rising edge; the new PC is visible after that edge (1-cycle latency).
- First valid fetch: in the second cycle after reset release, at RESET_VECTOR.
- After a redirect at edge N: target PC appears after N. INSTR_VALID=0 for BUBBLES unstalled cycles, then 1 at the target.
- The target address is fetched (valid) exactly once; the PC does not advance past the target while in BUBBLE.
- RESET asserted mid-BUBBLE or mid-stall: immediate return to the reset values.

## Structure
- Shared package pc_pkg:
  - state enum pc_state_t {BOOT, RUN, BUBBLE}
  - function clog2 for the alignment shift
  - default INSTR_BYTES constant shared with instruction memory
- Sub-module pc_target_calc (combinational): sign extension, shift, branch adder, jump alignment, MISALIGN detect, next-PC mux.
- pc_unit holds the registers, the FSM and the bubble counter.

## Test plan
- Reset release, RESET_VECTOR=0x100, no requests → PC 0x100 (invalid), then 0x100 (valid), 0x104, 0x108; PC_PLUS=PC+4.
- BRANCH_EN with OFFSET=−2 at PC=0x110, BUBBLES=1 → PC=0x10C, REDIRECT=1 one cycle, one invalid cycle, then 0x10C valid, then 0x110.
- JUMP_EN with TARGET=0x203 and BRANCH_EN together → PC=0x200, MISALIGN=1, branch ignored.
- STALL high for 3 cycles with JUMP_EN held, then STALL low → PC frozen for 3 cycles, jump taken on the first unstalled edge.
- WIDTH=8, PC=0xFC, sequential → PC=0x00, INSTR_VALID stays 1.
- RESET pulsed low asynchronously mid-BUBBLE (BUBBLES=3) → PC=RESET_VECTOR and INSTR_VALID=0 immediately, without a clock edge; BOOT follows.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit and its instruction-memory peers.
package pc_pkg;

  localparam int DEFAULT_INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } pc_state_t;

  // Ceiling log2, used for the instruction-alignment shift.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Redirect requests in, fetch address and status out.
// Handshake: requests have no ready; while STALL is high they are ignored and
// the requester keeps them asserted until STALL drops.
interface pc_unit_if #(
  parameter int WIDTH    = 32,
  parameter int OFFSET_W = 8
);
  logic                STALL;
  logic                BRANCH_EN;
  logic                JUMP_EN;
  logic [OFFSET_W-1:0] OFFSET;
  logic [WIDTH-1:0]    TARGET;
  logic [WIDTH-1:0]    PC;
  logic [WIDTH-1:0]    PC_PLUS;
  logic                INSTR_VALID;
  logic                REDIRECT;
  logic                MISALIGN;

  modport master (
    output STALL, BRANCH_EN, JUMP_EN, OFFSET, TARGET,
    input  PC, PC_PLUS, INSTR_VALID, REDIRECT, MISALIGN
  );

  modport slave (
    input  STALL, BRANCH_EN, JUMP_EN, OFFSET, TARGET,
    output PC, PC_PLUS, INSTR_VALID, REDIRECT, MISALIGN
  );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-address logic: link value, branch/jump targets, alignment check.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int INSTR_BYTES = DEFAULT_INSTR_BYTES,
  parameter int OFFSET_W    = 8
) (
  input  logic [WIDTH-1:0]    pc,
  input  logic                branch_en,
  input  logic                jump_en,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [WIDTH-1:0]    target,
  output logic [WIDTH-1:0]    pc_plus,
  output logic [WIDTH-1:0]    redir_pc,
  output logic                take,
  output logic                misalign
);
  localparam int               SH       = clog2(INSTR_BYTES);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INSTR_BYTES - 1);

  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] branch_pc;
  logic [WIDTH-1:0] jump_pc;

  assign pc_plus   = pc + WIDTH'(INSTR_BYTES);
  assign off_ext   = WIDTH'($signed(offset));
  // Offset counts instructions, so scale to bytes before adding to the link value.
  assign branch_pc = pc_plus + (off_ext << SH);
  assign jump_pc   = target & ~LOW_MASK;

  always_comb begin
    take     = jump_en | branch_en;
    redir_pc = jump_en ? jump_pc : branch_pc;
    misalign = jump_en & (|(target & LOW_MASK));
  end
endmodule

// File: rtl/pc_unit.sv
// Program counter: fetch address register, BOOT/RUN/BUBBLE sequencing and redirect handling.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INSTR_BYTES  = DEFAULT_INSTR_BYTES,
  parameter int               OFFSET_W     = 8,
  parameter int               BUBBLES      = 1
) (
  input  logic      CLK,
  input  logic      RESET,
  pc_unit_if.slave  bus,
  output pc_state_t DBG_STATE
);
  localparam logic [2:0] BUB_CNT = 3'(BUBBLES);

  pc_state_t        state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             redirect_q, redirect_d;
  logic             misalign_q, misalign_d;

  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] redir_pc;
  logic             take;
  logic             misalign;

  pc_target_calc #(
    .WIDTH       (WIDTH),
    .INSTR_BYTES (INSTR_BYTES),
    .OFFSET_W    (OFFSET_W)
  ) u_calc (
    .pc        (pc_q),
    .branch_en (bus.BRANCH_EN),
    .jump_en   (bus.JUMP_EN),
    .offset    (bus.OFFSET),
    .target    (bus.TARGET),
    .pc_plus   (pc_plus),
    .redir_pc  (redir_pc),
    .take      (take),
    .misalign  (misalign)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= BOOT;
      cnt_q      <= '0;
      pc_q       <= RESET_VECTOR;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    if (!bus.STALL) begin
      unique case (state_q)
        BOOT: begin
          state_d = RUN;
          valid_d = 1'b1;
        end
        RUN, BUBBLE: begin
          if (take) begin
            pc_d       = redir_pc;
            redirect_d = 1'b1;
            misalign_d = misalign;
            if (BUBBLES > 0) begin
              state_d = BUBBLE;
              cnt_d   = BUB_CNT;
              valid_d = 1'b0;
            end else begin
              state_d = RUN;
              valid_d = 1'b1;
            end
          end else if (state_q == BUBBLE) begin
            // PC parks on the target so it is fetched exactly once when the bubbles end.
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
              state_d = RUN;
              valid_d = 1'b1;
            end
          end else begin
            pc_d    = pc_plus;
            valid_d = 1'b1;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  assign bus.PC          = pc_q;
  assign bus.PC_PLUS     = pc_plus;
  assign bus.INSTR_VALID = valid_q;
  assign bus.REDIRECT    = redirect_q;
  assign bus.MISALIGN    = misalign_q;
  assign DBG_STATE       = state_q;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: a 32-bit unit with one bubble and an 8-bit unit with three bubbles.
module tb_pc_unit;
  import pc_pkg::*;

  logic      clk;
  logic      rst_a, rst_b;
  pc_state_t st_a, st_b;
  int        checks = 0;
  int        errors = 0;

  // Scoreboard entry: {pc, valid, redirect, misalign}
  logic [34:0] exp_q[$];

  pc_unit_if #(.WIDTH(32), .OFFSET_W(8)) ia ();
  pc_unit_if #(.WIDTH(8),  .OFFSET_W(6)) ib ();

  pc_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h100), .INSTR_BYTES(4), .OFFSET_W(8), .BUBBLES(1)
  ) dut_a (.CLK(clk), .RESET(rst_a), .bus(ia), .DBG_STATE(st_a));

  pc_unit #(
    .WIDTH(8), .RESET_VECTOR(8'hF8), .INSTR_BYTES(4), .OFFSET_W(6), .BUBBLES(3)
  ) dut_b (.CLK(clk), .RESET(rst_b), .bus(ib), .DBG_STATE(st_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, br, jmp;
    logic [7:0]  off;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        v, r, m;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic stall, br, jmp, input logic [7:0] off,
                              input logic [31:0] tgt, input logic [31:0] pc,
                              input logic v, r, m);
    vec_t x;
    x.stall = stall; x.br = br; x.jmp = jmp; x.off = off; x.tgt = tgt;
    x.pc = pc; x.v = v; x.r = r; x.m = m;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic b_cycle(input string name, input logic stall, br, jmp,
                         input logic [5:0] off, input logic [7:0] tgt,
                         input logic [7:0] pc, input logic v, r, m);
    logic [34:0] e;
    ib.STALL = stall; ib.BRANCH_EN = br; ib.JUMP_EN = jmp; ib.OFFSET = off; ib.TARGET = tgt;
    exp_q.push_back({24'h0, pc, v, r, m});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({name, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_pc"},    {24'h0, ib.PC},      e[34:3]);
      chk({name, "_plus"},  {24'h0, ib.PC_PLUS}, {24'h0, 8'(e[10:3] + 8'd4)});
      chk({name, "_valid"}, {31'h0, ib.INSTR_VALID}, {31'h0, e[2]});
      chk({name, "_redir"}, {31'h0, ib.REDIRECT},    {31'h0, e[1]});
      chk({name, "_mis"},   {31'h0, ib.MISALIGN},    {31'h0, e[0]});
    end
  endtask

  initial begin
    logic [34:0] e;
    rst_a = 1'b0; rst_b = 1'b0;
    ia.STALL = 0; ia.BRANCH_EN = 0; ia.JUMP_EN = 0; ia.OFFSET = '0; ia.TARGET = '0;
    ib.STALL = 0; ib.BRANCH_EN = 0; ib.JUMP_EN = 0; ib.OFFSET = '0; ib.TARGET = '0;

    //            stall br jmp off    tgt        pc         v  r  m
    vecs[0]  = mk(0, 0, 0, 8'h00, 32'h0,   32'h100, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 8'h00, 32'h0,   32'h104, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 8'h00, 32'h0,   32'h108, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 8'h00, 32'h0,   32'h10C, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 8'h00, 32'h0,   32'h110, 1, 0, 0);
    vecs[5]  = mk(0, 1, 0, 8'hFE, 32'h0,   32'h10C, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 8'h00, 32'h0,   32'h10C, 1, 0, 0);
    vecs[7]  = mk(0, 0, 0, 8'h00, 32'h0,   32'h110, 1, 0, 0);
    vecs[8]  = mk(0, 1, 1, 8'h05, 32'h203, 32'h200, 0, 1, 1);
    vecs[9]  = mk(0, 0, 0, 8'h00, 32'h0,   32'h200, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 8'h00, 32'h0,   32'h204, 1, 0, 0);
    vecs[11] = mk(1, 0, 1, 8'h00, 32'h300, 32'h204, 1, 0, 0);
    vecs[12] = mk(1, 0, 1, 8'h00, 32'h300, 32'h204, 1, 0, 0);
    vecs[13] = mk(1, 0, 1, 8'h00, 32'h300, 32'h204, 1, 0, 0);
    vecs[14] = mk(0, 0, 1, 8'h00, 32'h300, 32'h300, 0, 1, 0);
    vecs[15] = mk(1, 0, 0, 8'h00, 32'h0,   32'h300, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 8'h00, 32'h0,   32'h300, 1, 0, 0);
    vecs[17] = mk(0, 1, 0, 8'h03, 32'h0,   32'h310, 0, 1, 0);
    vecs[18] = mk(0, 0, 1, 8'h00, 32'h400, 32'h400, 0, 1, 0);
    vecs[19] = mk(0, 0, 0, 8'h00, 32'h0,   32'h400, 1, 0, 0);
    vecs[20] = mk(0, 1, 0, 8'h80, 32'h0,   32'h204, 0, 1, 0);
    vecs[21] = mk(0, 0, 0, 8'h00, 32'h0,   32'h204, 1, 0, 0);
    vecs[22] = mk(0, 0, 0, 8'h00, 32'h0,   32'h208, 1, 0, 0);

    #12;
    chk("a_rst_pc",    ia.PC,      32'h100);
    chk("a_rst_plus",  ia.PC_PLUS, 32'h104);
    chk("a_rst_valid", {31'h0, ia.INSTR_VALID}, 32'h0);
    chk("a_rst_redir", {31'h0, ia.REDIRECT},    32'h0);
    chk("a_rst_mis",   {31'h0, ia.MISALIGN},    32'h0);
    chk("a_rst_state", 32'(st_a), 32'(BOOT));
    chk("b_rst_pc",    {24'h0, ib.PC},      32'hF8);
    chk("b_rst_plus",  {24'h0, ib.PC_PLUS}, 32'hFC);
    rst_a = 1'b1;

    for (int i = 0; i < 23; i++) begin
      ia.STALL = vecs[i].stall; ia.BRANCH_EN = vecs[i].br; ia.JUMP_EN = vecs[i].jmp;
      ia.OFFSET = vecs[i].off;  ia.TARGET = vecs[i].tgt;
      exp_q.push_back({vecs[i].pc, vecs[i].v, vecs[i].r, vecs[i].m});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk($sformatf("a%0d_queue", i), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("a%0d_pc", i),    ia.PC,      e[34:3]);
        chk($sformatf("a%0d_plus", i),  ia.PC_PLUS, e[34:3] + 32'd4);
        chk($sformatf("a%0d_valid", i), {31'h0, ia.INSTR_VALID}, {31'h0, e[2]});
        chk($sformatf("a%0d_redir", i), {31'h0, ia.REDIRECT},    {31'h0, e[1]});
        chk($sformatf("a%0d_mis", i),   {31'h0, ia.MISALIGN},    {31'h0, e[0]});
      end
    end
    ia.STALL = 0; ia.BRANCH_EN = 0; ia.JUMP_EN = 0;

    // 8-bit unit: wrap through zero, negative branch below zero, three bubbles.
    rst_b = 1'b1;
    b_cycle("b1",  0, 0, 0, 6'h00, 8'h00, 8'hF8, 1, 0, 0);
    b_cycle("b2",  0, 0, 0, 6'h00, 8'h00, 8'hFC, 1, 0, 0);
    b_cycle("b3",  0, 0, 0, 6'h00, 8'h00, 8'h00, 1, 0, 0);
    b_cycle("b4",  0, 1, 0, 6'h3C, 8'h00, 8'hF4, 0, 1, 0);
    b_cycle("b5",  0, 0, 0, 6'h00, 8'h00, 8'hF4, 0, 0, 0);
    b_cycle("b6",  0, 0, 0, 6'h00, 8'h00, 8'hF4, 0, 0, 0);
    b_cycle("b7",  0, 0, 0, 6'h00, 8'h00, 8'hF4, 1, 0, 0);
    b_cycle("b8",  0, 0, 0, 6'h00, 8'h00, 8'hF8, 1, 0, 0);
    b_cycle("b9",  0, 0, 1, 6'h00, 8'h13, 8'h10, 0, 1, 1);
    b_cycle("b10", 0, 0, 0, 6'h00, 8'h00, 8'h10, 0, 0, 0);
    chk("b10_state", 32'(st_b), 32'(BUBBLE));

    // Reset between clock edges must take effect on its own.
    #3;
    rst_b = 1'b0;
    #1;
    chk("b_async_pc",    {24'h0, ib.PC}, 32'hF8);
    chk("b_async_valid", {31'h0, ib.INSTR_VALID}, 32'h0);
    chk("b_async_redir", {31'h0, ib.REDIRECT},    32'h0);
    chk("b_async_state", 32'(st_b), 32'(BOOT));
    #2;
    rst_b = 1'b1;
    b_cycle("b11", 1, 0, 0, 6'h00, 8'h00, 8'hF8, 0, 0, 0);
    chk("b11_state", 32'(st_b), 32'(BOOT));
    b_cycle("b12", 0, 0, 0, 6'h00, 8'h00, 8'hF8, 1, 0, 0);
    chk("b12_state", 32'(st_b), 32'(RUN));

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
